debug_host: RTL and testbench
=============================

# debug_host

Host-side initiator for the MIPS serial debug link: the far end of the debug UART. It serializes one command byte onto `tx` (8N1, 16x oversampled) and collects a 0–2 byte little-endian response from `rx`, for example a 10-bit PC value. The result is presented as one word. It sits in board self-test and loopback builds, driving the debug unit's serial pins, and shares the codebase's 16x baud tick.

## Interface
- `OVERSAMPLE`, default 16: ticks per bit.
- `TIMEOUT_TICKS`, default 65535: ticks allowed between command stop bit and last response byte.
- `clk` in 1: system clock.
- `rst` in 1: reset; synchronous, active-high.
- `tick` in 1: one-cycle baud enable, OVERSAMPLE × baud rate.
- `cmd_valid` in 1: command request.
- `cmd_ready` out 1: high only in IDLE.
- `cmd_byte` in 8: byte to transmit.
- `resp_len` in 2: expected response bytes, 0..2; value 3 is treated as 2.
- `rx` in 1: serial from the debug unit; idle high; pre-synchronized.
- `tx` out 1: serial to the debug unit; idle high.
- `resp_valid` out 1: one-cycle pulse, response complete.
- `resp_data` out 16: {byte1, byte0}; unreceived bytes read as zero.
- `timeout` out 1: one-cycle pulse, response abandoned.
- `frame_err` out 1: one-cycle pulse, received byte with low stop bit.
- `busy` out 1: high when not IDLE.

## Operation
- **FSM states:** IDLE, SEND, WAIT_RESP, DONE.
- **IDLE:**
  - `cmd_valid && cmd_ready` latches `cmd_byte` and `resp_len`, clears `resp_data` and the byte index, then goes to SEND.
- **SEND:**
  - Transmitter emits start bit (0), data bits LSB first, stop bit (1); each bit lasts OVERSAMPLE ticks.
  - At the end of the stop bit: go to DONE if `resp_len`==0, else WAIT_RESP.
- **WAIT_RESP:**
  - Each good received byte goes to `resp_data[8*idx +: 8]`, then idx increments.
  - When idx reaches `resp_len`, go to DONE.
  - A frame_err byte is discarded and idx does not advance.
- **DONE:** pulse `resp_valid` for one cycle, then go to IDLE.
- **Receiver** (free-running):
  - A low level on a tick arms a start check.
  - At the mid-bit tick (OVERSAMPLE/2) the line is re-sampled. If high, it was a glitch and the receiver returns to idle.
  - Data bits are sampled at each following mid-bit tick.
  - The stop bit is sampled; if low, `frame_err` pulses.
  - Bytes completing outside WAIT_RESP are dropped silently.
- **Simultaneous events:**
  - A byte completing on the same cycle as timeout expiry is accepted; timeout does not fire.
  - `cmd_valid` during DONE is ignored (`cmd_ready`=0).
- **Reset mid-frame:**
  - `tx` goes high immediately and the FSM returns to IDLE.
  - The receiver aborts its partial byte.

## Timing
- **Reset values:**
  - `tx`=1, `cmd_ready`=1 (IDLE).
  - `busy`=0, `resp_valid`=0, `timeout`=0, `frame_err`=0, `resp_data`=0.
- **Command start:** `tx` falls on the first `tick` after acceptance. Latency from acceptance to start-bit edge is ≤ one tick period + 1 clk.
- **Frame length:** 10×OVERSAMPLE ticks (160 at default).
- **Receive timing:** a received byte is committed 1 clk after the stop-bit sample tick, about 9.5 bits after the start edge.
- **Response completion:** `resp_valid` is asserted 1 clk after the final byte commit; `resp_data` is stable from that cycle until the next acceptance.
- **Outputs:** all are registered; no combinational path from `rx` or `cmd_valid` to any output.

## Configuration
- **`DEBUG_HOST_TIMEOUT_EN` defined:**
  - A 16-bit tick counter runs in WAIT_RESP and reloads on each accepted byte.
  - Reaching TIMEOUT_TICKS pulses `timeout` and returns the FSM to IDLE. `resp_data` holds the partial bytes.
- **Undefined:**
  - No counter is built and `timeout` is tied to 0.
  - WAIT_RESP waits indefinitely; only `rst` exits it.

## Structure
- **Shared package `debug_pkg`:**
  - State enum `debug_host_state_t`.
  - Command constants: `DBG_CMD_RUN`=8'h63, `DBG_CMD_STEP`=8'h73, `DBG_CMD_READ_PC`=8'h70.
  - `DBG_PC_RESP_LEN`=2.
- **Sub-module `debug_host_rx`:** 8N1 oversampling deserializer. Outputs `byte_valid`, `byte_data`, `frame_err`.
- **Top level:** transmitter shift logic and control FSM stay in `debug_host`.

## Test plan
- **Read PC:**
  - Stimulus: `cmd_byte`=8'h70, `resp_len`=2; device model replies 8'hA5 then 8'h03.
  - Required: `tx` frame decodes to 8'h70; `resp_valid` pulses once; `resp_data`=16'h03A5.
  - Required: `busy` is high for the whole exchange.
- **Zero-length command:**
  - Stimulus: `cmd_byte`=8'h73, `resp_len`=0.
  - Required: `resp_valid` 1 clk after the stop bit ends, 160 ticks after start; `resp_data`=0.
- **Framing error:**
  - Stimulus: first reply byte has stop bit 0, then valid 8'h12, 8'h34.
  - Required: one `frame_err` pulse; `resp_data`=16'h3412.
- **Start glitch:**
  - Stimulus: `rx` low for 3 ticks during WAIT_RESP, then a valid 8'h55.
  - Required: no byte from the glitch; `resp_data[7:0]`=8'h55.
- **Timeout (`DEBUG_HOST_TIMEOUT_EN`, TIMEOUT_TICKS=200):**
  - Stimulus: one of two reply bytes (8'h7E) is sent.
  - Required: `timeout` pulses 200 ticks after it; `resp_data`=16'h007E; `cmd_ready`=1 next cycle.
- **Reset mid-transmit:**
  - Stimulus: `rst` asserted during data bit 4.
  - Required: `tx`=1 next clk, then IDLE; a new command afterwards sends a complete, correct frame.

Source files
------------

// File: rtl/debug_pkg.sv
// Shared types and constants for the MIPS serial debug link host side.
// Holds the FSM state enums, command codes and the response-length normalizer.
package debug_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        WAIT_RESP,
        DONE
    } debug_host_state_t;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } debug_rx_state_t;

    localparam logic [7:0] DBG_CMD_RUN     = 8'h63;
    localparam logic [7:0] DBG_CMD_STEP    = 8'h73;
    localparam logic [7:0] DBG_CMD_READ_PC = 8'h70;
    localparam logic [1:0] DBG_PC_RESP_LEN = 2'd2;

    // The link carries at most two response bytes; a request for three is clamped.
    function automatic logic [1:0] norm_resp_len(input logic [1:0] len);
        return (len == 2'd3) ? 2'd2 : len;
    endfunction

endpackage

// File: rtl/debug_host_rx.sv
// 8N1 oversampling deserializer for the debug link receive pin.
// Latency: byte_valid/frame_err pulse 1 clk after the stop-bit sample tick (~9.5 bits after start).
// Backpressure: none; free-running, each byte is a single-cycle pulse the consumer must take.
module debug_host_rx
    import debug_pkg::*;
#(
    parameter int OVERSAMPLE = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic       rx,
    output logic       byte_valid,
    output logic [7:0] byte_data,
    output logic       frame_err
);

    localparam int CW = (OVERSAMPLE > 2) ? $clog2(OVERSAMPLE) : 1;
    localparam logic [CW-1:0] MID_LAST = CW'(OVERSAMPLE / 2 - 1);
    localparam logic [CW-1:0] BIT_LAST = CW'(OVERSAMPLE - 1);

    debug_rx_state_t state;
    logic [CW-1:0]   cnt;
    logic [2:0]      bit_idx;
    logic [7:0]      shreg;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= RX_IDLE;
            cnt        <= '0;
            bit_idx    <= '0;
            shreg      <= '0;
            byte_valid <= 1'b0;
            byte_data  <= '0;
            frame_err  <= 1'b0;
        end else begin
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
            if (tick) begin
                case (state)
                    RX_IDLE: begin
                        cnt <= '0;
                        if (!rx) state <= RX_START;
                    end
                    RX_START: begin
                        // Re-check mid start bit; a high line here means the low was a glitch.
                        if (cnt == MID_LAST) begin
                            cnt     <= '0;
                            bit_idx <= '0;
                            state   <= rx ? RX_IDLE : RX_DATA;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    RX_DATA: begin
                        if (cnt == BIT_LAST) begin
                            cnt     <= '0;
                            shreg   <= {rx, shreg[7:1]};
                            bit_idx <= bit_idx + 1'b1;
                            if (bit_idx == 3'd7) state <= RX_STOP;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    RX_STOP: begin
                        if (cnt == BIT_LAST) begin
                            cnt   <= '0;
                            state <= RX_IDLE;
                            if (rx) begin
                                byte_valid <= 1'b1;
                                byte_data  <= shreg;
                            end else begin
                                frame_err <= 1'b1;
                            end
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    default: state <= RX_IDLE;
                endcase
            end
        end
    end

endmodule

// File: rtl/debug_host.sv
// Debug-link host: sends one 8N1 command byte on tx, collects a 0-2 byte LE response from rx.
// Latency: tx start edge on first tick after accept; resp_valid 1 clk after last byte commit. Optional DEBUG_HOST_TIMEOUT_EN.
// Backpressure: cmd_ready is high only in IDLE; commands offered at any other time are not taken.
module debug_host
    import debug_pkg::*;
#(
    parameter int OVERSAMPLE    = 16,
    parameter int TIMEOUT_TICKS = 65535
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        tick,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [7:0]  cmd_byte,
    input  logic [1:0]  resp_len,
    input  logic        rx,
    output logic        tx,
    output logic        resp_valid,
    output logic [15:0] resp_data,
    output logic        timeout,
    output logic        frame_err,
    output logic        busy
);

    localparam int CW = (OVERSAMPLE > 2) ? $clog2(OVERSAMPLE) : 1;
    localparam logic [CW-1:0] BIT_LAST = CW'(OVERSAMPLE - 1);

    debug_host_state_t state;
    logic [9:0]        tx_shift;
    logic              tx_active;
    logic [CW-1:0]     tx_cnt;
    logic [3:0]        tx_bit;
    logic [1:0]        rlen;
    logic [1:0]        idx;

    logic              rx_byte_vld;
    logic [7:0]        rx_byte_dat;
    logic              rx_frame_err;

    debug_host_rx #(
        .OVERSAMPLE(OVERSAMPLE)
    ) u_rx (
        .clk       (clk),
        .rst       (rst),
        .tick      (tick),
        .rx        (rx),
        .byte_valid(rx_byte_vld),
        .byte_data (rx_byte_dat),
        .frame_err (rx_frame_err)
    );

    assign frame_err = rx_frame_err;

`ifdef DEBUG_HOST_TIMEOUT_EN
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT_TICKS - 1);
    logic [15:0] to_cnt;
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            tx         <= 1'b1;
            cmd_ready  <= 1'b1;
            busy       <= 1'b0;
            resp_valid <= 1'b0;
            resp_data  <= '0;
            tx_shift   <= '1;
            tx_active  <= 1'b0;
            tx_cnt     <= '0;
            tx_bit     <= '0;
            rlen       <= '0;
            idx        <= '0;
`ifdef DEBUG_HOST_TIMEOUT_EN
            to_cnt     <= '0;
            timeout    <= 1'b0;
`endif
        end else begin
            resp_valid <= 1'b0;
`ifdef DEBUG_HOST_TIMEOUT_EN
            timeout    <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (cmd_valid && cmd_ready) begin
                        tx_shift  <= {1'b1, cmd_byte, 1'b0};
                        rlen      <= norm_resp_len(resp_len);
                        resp_data <= '0;
                        idx       <= '0;
                        tx_active <= 1'b0;
                        cmd_ready <= 1'b0;
                        busy      <= 1'b1;
                        state     <= SEND;
                    end
                end
                SEND: begin
                    if (tick) begin
                        // First tick after accept emits the start bit; then one bit per OVERSAMPLE ticks.
                        if (!tx_active) begin
                            tx        <= tx_shift[0];
                            tx_shift  <= {1'b1, tx_shift[9:1]};
                            tx_active <= 1'b1;
                            tx_cnt    <= '0;
                            tx_bit    <= '0;
                        end else if (tx_cnt == BIT_LAST) begin
                            tx_cnt <= '0;
                            if (tx_bit == 4'd9) begin
                                tx        <= 1'b1;
                                tx_active <= 1'b0;
                                if (rlen == 2'd0) begin
                                    state      <= DONE;
                                    resp_valid <= 1'b1;
                                end else begin
                                    state <= WAIT_RESP;
                                end
`ifdef DEBUG_HOST_TIMEOUT_EN
                                to_cnt <= '0;
`endif
                            end else begin
                                tx       <= tx_shift[0];
                                tx_shift <= {1'b1, tx_shift[9:1]};
                                tx_bit   <= tx_bit + 1'b1;
                            end
                        end else begin
                            tx_cnt <= tx_cnt + 1'b1;
                        end
                    end
                end
                WAIT_RESP: begin
                    // A byte landing on the expiry tick wins over the timeout.
                    if (rx_byte_vld) begin
                        if (idx[0]) resp_data[15:8] <= rx_byte_dat;
                        else        resp_data[7:0]  <= rx_byte_dat;
                        idx <= idx + 1'b1;
`ifdef DEBUG_HOST_TIMEOUT_EN
                        to_cnt <= '0;
`endif
                        if (idx + 2'd1 == rlen) begin
                            state      <= DONE;
                            resp_valid <= 1'b1;
                        end
                    end
`ifdef DEBUG_HOST_TIMEOUT_EN
                    else if (tick) begin
                        if (to_cnt == TO_LAST) begin
                            timeout   <= 1'b1;
                            state     <= IDLE;
                            cmd_ready <= 1'b1;
                            busy      <= 1'b0;
                        end else begin
                            to_cnt <= to_cnt + 1'b1;
                        end
                    end
`endif
                end
                DONE: begin
                    state     <= IDLE;
                    cmd_ready <= 1'b1;
                    busy      <= 1'b0;
                end
                default: begin
                    state     <= IDLE;
                    cmd_ready <= 1'b1;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_debug_host.sv
// Directed bench for debug_host: table of command/response exchanges plus hand-written corner cases.
// The timeout sequence is compiled in only when DEBUG_HOST_TIMEOUT_EN is defined.
module tb_debug_host;

    logic        clk;
    logic        rst;
    logic        tick;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [7:0]  cmd_byte;
    logic [1:0]  resp_len;
    logic        rx;
    logic        tx;
    logic        resp_valid;
    logic [15:0] resp_data;
    logic        timeout;
    logic        frame_err;
    logic        busy;

    debug_host #(
        .OVERSAMPLE   (16),
        .TIMEOUT_TICKS(200)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .tick      (tick),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_byte  (cmd_byte),
        .resp_len  (resp_len),
        .rx        (rx),
        .tx        (tx),
        .resp_valid(resp_valid),
        .resp_data (resp_data),
        .timeout   (timeout),
        .frame_err (frame_err),
        .busy      (busy)
    );

    typedef struct {
        logic [7:0]  cmd;
        logic [1:0]  len;
        int          nbytes;
        logic [7:0]  b0;
        logic [7:0]  b1;
        logic [7:0]  b2;
        bit          bad_first;
        logic [15:0] exp_data;
        int          exp_fe;
    } vec_t;

    vec_t vecs[5];

    int checks = 0;
    int failures = 0;
    int n_rv = 0;
    int n_fe = 0;
    int n_to = 0;
    int busy_gap = 0;
    bit in_xact = 0;
    logic [1:0] tick_div = 2'd0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // One-clock tick every 4 clocks, changed on the falling edge.
    initial begin
        tick = 1'b0;
        forever begin
            @(negedge clk);
            tick_div = tick_div + 2'd1;
            tick = (tick_div == 2'd0);
        end
    end

    always @(posedge clk) begin
        if (resp_valid) n_rv++;
        if (frame_err) n_fe++;
        if (timeout) n_to++;
        if (in_xact && !busy && n_rv == 0) busy_gap++;
    end

    initial begin
        #800000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_tick();
        @(posedge clk);
        while (!tick) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic wait_ticks(input int n);
        repeat (n) wait_tick();
    endtask

    task automatic send_byte(input logic [7:0] d, input bit stop);
        wait_tick();
        rx = 1'b0;
        wait_ticks(16);
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            wait_ticks(16);
        end
        rx = stop;
        wait_ticks(16);
        rx = 1'b1;
    endtask

    task automatic issue(input logic [7:0] c, input logic [1:0] l);
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_byte  = c;
        resp_len  = l;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_fall(output int fw);
        fw = 0;
        while (tx !== 1'b0 && fw < 50) begin
            @(negedge clk);
            fw++;
        end
    endtask

    // Decodes one frame from tx by sampling mid-bit, starting from the start edge.
    task automatic decode_tx(output logic [7:0] b, output int fw, output bit framed);
        logic s0;
        logic s9;
        b = 8'h00;
        framed = 1'b0;
        wait_fall(fw);
        if (tx === 1'b0) begin
            wait_ticks(8);
            s0 = tx;
            for (int i = 0; i < 8; i++) begin
                wait_ticks(16);
                b[i] = tx;
            end
            wait_ticks(16);
            s9 = tx;
            framed = (s0 == 1'b0) && (s9 == 1'b1);
        end
    endtask

    task automatic wait_rv();
        int cyc = 0;
        while (n_rv == 0 && cyc < 3000) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        logic [7:0] b;
        logic [7:0] bytes[3];
        int fw;
        bit framed;
        string tag;
        bytes[0] = v.b0;
        bytes[1] = v.b1;
        bytes[2] = v.b2;
        tag = $sformatf("vec%0d", idx);
        n_rv = 0;
        n_fe = 0;
        busy_gap = 0;
        check({tag, "_ready_before"}, {31'd0, cmd_ready}, 32'd1);
        issue(v.cmd, v.len);
        in_xact = 1'b1;
        decode_tx(b, fw, framed);
        check({tag, "_tx_byte"}, {24'd0, b}, {24'd0, v.cmd});
        check({tag, "_tx_framing"}, {31'd0, framed}, 32'd1);
        check({tag, "_start_latency_ok"}, {31'd0, (fw >= 1 && fw <= 5)}, 32'd1);
        if (v.nbytes > 0) begin
            wait_ticks(10);
            for (int j = 0; j < v.nbytes; j++) begin
                send_byte(bytes[j], !(v.bad_first && j == 0));
                wait_ticks((v.bad_first && j == 0) ? 32 : 2);
            end
        end
        wait_rv();
        repeat (20) @(negedge clk);
        in_xact = 1'b0;
        check({tag, "_resp_valid_pulses"}, n_rv, 1);
        check({tag, "_resp_data"}, {16'd0, resp_data}, {16'd0, v.exp_data});
        check({tag, "_frame_err_pulses"}, n_fe, v.exp_fe);
        check({tag, "_busy_drops"}, busy_gap, 0);
        check({tag, "_ready_after"}, {31'd0, cmd_ready}, 32'd1);
    endtask

    initial begin
        logic [7:0] b;
        int fw;
        bit framed;

        vecs[0] = '{8'h70, 2'd2, 2, 8'hA5, 8'h03, 8'h00, 1'b0, 16'h03A5, 0};
        vecs[1] = '{8'h73, 2'd0, 0, 8'h00, 8'h00, 8'h00, 1'b0, 16'h0000, 0};
        vecs[2] = '{8'h63, 2'd1, 1, 8'h5A, 8'h00, 8'h00, 1'b0, 16'h005A, 0};
        vecs[3] = '{8'h70, 2'd3, 2, 8'h11, 8'h22, 8'h00, 1'b0, 16'h2211, 0};
        vecs[4] = '{8'h70, 2'd2, 3, 8'h99, 8'h12, 8'h34, 1'b1, 16'h3412, 1};

        rst = 1'b1;
        cmd_valid = 1'b0;
        cmd_byte = 8'h00;
        resp_len = 2'd0;
        rx = 1'b1;
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("rst_tx", {31'd0, tx}, 32'd1);
        check("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        check("rst_timeout", {31'd0, timeout}, 32'd0);
        check("rst_frame_err", {31'd0, frame_err}, 32'd0);
        check("rst_resp_data", {16'd0, resp_data}, 32'd0);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        for (int i = 0; i < 5; i++) run_vec(i, vecs[i]);

        // Zero-length command: resp_valid exactly 160 ticks after the start edge.
        n_rv = 0;
        issue(8'h73, 2'd0);
        wait_fall(fw);
        check("zl_tx_fell", {31'd0, tx}, 32'd0);
        wait_ticks(159);
        check("zl_resp_valid_early", {31'd0, resp_valid}, 32'd0);
        wait_tick();
        check("zl_resp_valid_on_time", {31'd0, resp_valid}, 32'd1);
        check("zl_resp_data", {16'd0, resp_data}, 32'd0);
        @(negedge clk);
        check("zl_resp_valid_one_cycle", {31'd0, resp_valid}, 32'd0);
        repeat (4) @(negedge clk);

        // Start glitch during WAIT_RESP must not produce a byte.
        n_rv = 0;
        n_fe = 0;
        issue(8'h70, 2'd1);
        decode_tx(b, fw, framed);
        check("gl_tx_byte", {24'd0, b}, 32'h70);
        wait_ticks(10);
        rx = 1'b0;
        wait_ticks(3);
        rx = 1'b1;
        wait_ticks(20);
        check("gl_no_byte", n_rv, 0);
        check("gl_busy", {31'd0, busy}, 32'd1);
        send_byte(8'h55, 1'b1);
        wait_rv();
        repeat (4) @(negedge clk);
        check("gl_resp_valid_pulses", n_rv, 1);
        check("gl_resp_byte0", {24'd0, resp_data[7:0]}, 32'h55);
        check("gl_frame_err", n_fe, 0);

`ifdef DEBUG_HOST_TIMEOUT_EN
        // One of two bytes arrives; timeout fires 200 ticks after its commit.
        n_rv = 0;
        n_to = 0;
        issue(8'h70, 2'd2);
        decode_tx(b, fw, framed);
        wait_ticks(10);
        send_byte(8'h7E, 1'b1);
        wait_ticks(192);
        check("to_not_early", n_to, 0);
        wait_tick();
        check("to_pulse", {31'd0, timeout}, 32'd1);
        check("to_resp_data", {16'd0, resp_data}, 32'h007E);
        @(negedge clk);
        check("to_pulse_one_cycle", {31'd0, timeout}, 32'd0);
        check("to_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        check("to_no_resp_valid", n_rv, 0);
        repeat (4) @(negedge clk);
`endif

        // Reset in the middle of data bit 4, then a clean exchange.
        issue(8'h63, 2'd0);
        wait_fall(fw);
        wait_ticks(88);
        check("mr_tx_bit4_low", {31'd0, tx}, 32'd0);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("mr_tx_high", {31'd0, tx}, 32'd1);
        check("mr_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        check("mr_busy", {31'd0, busy}, 32'd0);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        n_rv = 0;
        issue(8'h70, 2'd0);
        decode_tx(b, fw, framed);
        check("mr_new_tx_byte", {24'd0, b}, 32'h70);
        check("mr_new_tx_framing", {31'd0, framed}, 32'd1);
        wait_rv();
        repeat (4) @(negedge clk);
        check("mr_new_resp_valid", n_rv, 1);

`ifndef DEBUG_HOST_TIMEOUT_EN
        check("no_timeout_ever", n_to, 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
